// File: rtl/vram_fetch_scheduler_if.sv
// VRAM port bundle: the CPU request/ack handshake plus the shared VRAM address/strobe outputs.
// The slave side is the scheduler, and the master side is the CPU bus and VRAM.
interface vram_fetch_scheduler_if #(
  parameter int unsigned ADDR_W = 13
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ack;
  logic [ADDR_W-1:0] vram_addr;
  logic              vram_we;
  logic              disp_fetch;

  modport master (
    output cpu_req, cpu_we, cpu_addr,
    input  cpu_ack, vram_addr, vram_we, disp_fetch
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr,
    output cpu_ack, vram_addr, vram_we, disp_fetch
  );
endinterface

// File: rtl/vram_fetch_scheduler.sv
// VRAM fetch scheduler.
// Tracks lines from the sync edges and runs one display fetch per slot on active lines.
// Slot cycle 0 belongs to the display. The CPU gets the VRAM port in every other cycle.
module vram_fetch_scheduler #(
  parameter logic [8:0]  LEFT_BORDER    = 9'd60,
  parameter logic [5:0]  BYTES_PER_LINE = 6'd32,
  parameter logic [3:0]  SLOT_CYCLES    = 4'd8,
  parameter logic [8:0]  TOP_BORDER     = 9'd25,
  parameter logic [8:0]  ACTIVE_LINES   = 9'd192,
  parameter logic [3:0]  LINES_PER_ROW  = 4'd12,
  parameter int unsigned ADDR_W         = 13
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hsn,
  input  logic                   fsn,
  input  logic [ADDR_W-1:0]      base_addr,
  vram_fetch_scheduler_if.slave  bus,
  output logic                   preload,
  output logic                   rowclear,
  output logic                   active
);

  typedef enum logic [1:0] {StIdle, StBorder, StFetch, StDone} state_e;

  state_e            state_q, state_d;
  logic              hsn_q, fsn_q;
  logic [8:0]        line_cnt_q, line_cnt_d, line_inc;
  logic [ADDR_W-1:0] row_addr_q, row_addr_d;
  logic [3:0]        scan_q, scan_d;
  logic [8:0]        col_q, col_d;
  logic [5:0]        slot_q, slot_d;
  logic [3:0]        sc_q, sc_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
  logic              vram_we_q, vram_we_d;
  logic              disp_fetch_q, disp_fetch_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              preload_q, preload_d;
  logic              rowclear_q, rowclear_d;
  logic              active_q, active_d;
  logic              hrise, frise, new_line_act, disp_slot, grant;

  assign hrise = hsn & ~hsn_q;
  assign frise = fsn & ~fsn_q;
  assign line_inc = (line_cnt_q == 9'h1FF) ? line_cnt_q : line_cnt_q + 9'd1;
  // frise wins over a coincident hrise, so that line is never counted or started
  assign new_line_act = hrise & ~frise &
                        ({1'b0, line_inc} >= {1'b0, TOP_BORDER}) &
                        ({1'b0, line_inc} < ({1'b0, TOP_BORDER} + {1'b0, ACTIVE_LINES}));
  assign disp_slot = (state_q == StFetch) && (sc_q == 4'd0);
  // No grant while the ack is showing, so a held request waits one idle cycle
  assign grant = bus.cpu_req & ~cpu_ack_q & ~disp_slot;

  // Next-state logic for the vertical tracking, the line FSM and the VRAM port
  always_comb begin
    state_d      = state_q;
    line_cnt_d   = line_cnt_q;
    row_addr_d   = row_addr_q;
    scan_d       = scan_q;
    col_d        = col_q;
    slot_d       = slot_q;
    sc_d         = sc_q;
    fetch_addr_d = fetch_addr_q;
    preload_d    = 1'b0;
    rowclear_d   = 1'b0;
    disp_fetch_d = 1'b0;
    vram_addr_d  = vram_addr_q;
    vram_we_d    = 1'b0;
    cpu_ack_d    = 1'b0;

    if (frise) begin
      line_cnt_d = 9'd0;
    end else if (hrise) begin
      line_cnt_d = line_inc;
    end

    unique case (state_q)
      StIdle: begin
        if (new_line_act) begin
          state_d = StBorder;
          col_d   = 9'd0;
        end
      end
      StBorder: begin
        col_d = col_q + 9'd1;
        if (col_q == LEFT_BORDER - 9'd2) preload_d = 1'b1;
        if (col_q == LEFT_BORDER - 9'd1) begin
          state_d      = StFetch;
          slot_d       = 6'd0;
          sc_d         = 4'd0;
          fetch_addr_d = row_addr_q;
          rowclear_d   = (scan_q == 4'd0);
        end
      end
      StFetch: begin
        if (sc_q == 4'd0) begin
          disp_fetch_d = 1'b1;
          fetch_addr_d = fetch_addr_q + ADDR_W'(1);
        end
        if (sc_q == SLOT_CYCLES - 4'd1) begin
          sc_d   = 4'd0;
          slot_d = slot_q + 6'd1;
          if (slot_q == BYTES_PER_LINE - 6'd1) state_d = StDone;
        end else begin
          sc_d = sc_q + 4'd1;
        end
      end
      StDone: begin
        if (scan_q == LINES_PER_ROW - 4'd1) begin
          scan_d     = 4'd0;
          row_addr_d = row_addr_q + ADDR_W'(BYTES_PER_LINE);
        end else begin
          scan_d = scan_q + 4'd1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (frise) begin
      state_d      = StIdle;
      row_addr_d   = base_addr;
      scan_d       = 4'd0;
      preload_d    = 1'b0;
      rowclear_d   = 1'b0;
      disp_fetch_d = 1'b0;
    end else if (hrise && state_q != StIdle) begin
      // Abort the current line without advancing the row or the scanline.
      // The same hrise then decides whether the next line starts.
      preload_d    = 1'b0;
      rowclear_d   = 1'b0;
      disp_fetch_d = 1'b0;
      state_d      = new_line_act ? StBorder : StIdle;
      col_d        = 9'd0;
    end

    if (disp_fetch_d) begin
      vram_addr_d = fetch_addr_q;
    end else if (grant) begin
      vram_addr_d = bus.cpu_addr;
      vram_we_d   = bus.cpu_we;
      cpu_ack_d   = 1'b1;
    end

    active_d = (state_d == StFetch);
  end

  // State and registered outputs; the sync copies reset high so release shows no edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      hsn_q        <= 1'b1;
      fsn_q        <= 1'b1;
      line_cnt_q   <= 9'd0;
      row_addr_q   <= '0;
      scan_q       <= 4'd0;
      col_q        <= 9'd0;
      slot_q       <= 6'd0;
      sc_q         <= 4'd0;
      fetch_addr_q <= '0;
      vram_addr_q  <= '0;
      vram_we_q    <= 1'b0;
      disp_fetch_q <= 1'b0;
      cpu_ack_q    <= 1'b0;
      preload_q    <= 1'b0;
      rowclear_q   <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hsn_q        <= hsn;
      fsn_q        <= fsn;
      line_cnt_q   <= line_cnt_d;
      row_addr_q   <= row_addr_d;
      scan_q       <= scan_d;
      col_q        <= col_d;
      slot_q       <= slot_d;
      sc_q         <= sc_d;
      fetch_addr_q <= fetch_addr_d;
      vram_addr_q  <= vram_addr_d;
      vram_we_q    <= vram_we_d;
      disp_fetch_q <= disp_fetch_d;
      cpu_ack_q    <= cpu_ack_d;
      preload_q    <= preload_d;
      rowclear_q   <= rowclear_d;
      active_q     <= active_d;
    end
  end

  assign bus.vram_addr  = vram_addr_q;
  assign bus.vram_we    = vram_we_q;
  assign bus.disp_fetch = disp_fetch_q;
  assign bus.cpu_ack    = cpu_ack_q;
  assign preload        = preload_q;
  assign rowclear       = rowclear_q;
  assign active         = active_q;

endmodule

// File: tb/tb_vram_fetch_scheduler.sv
// Bench for vram_fetch_scheduler.
// The line/row model pushes expected fetches and CPU accesses into queues,
// and a negedge monitor pops and compares them as the DUT produces them.
module tb_vram_fetch_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsn, fsn;
  logic [12:0] base_addr;
  logic        preload, rowclear, active;

  vram_fetch_scheduler_if #(.ADDR_W(13)) bus ();

  vram_fetch_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .hsn       (hsn),
    .fsn       (fsn),
    .base_addr (base_addr),
    .bus       (bus),
    .preload   (preload),
    .rowclear  (rowclear),
    .active    (active)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [12:0] addr; logic rc; logic first; } fetch_t;
  typedef struct packed { logic [12:0] addr; logic we; } cpu_t;

  fetch_t fq[$];
  cpu_t   cq[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_fetch = 0;
  int rc_seen = 0;
  int exp_rc = 0;

  // line model
  int          m_line = 0;
  logic [12:0] m_row = '0;
  int          m_scan = 0;
  logic        m_act = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: compare DUT events against the queued expectations
  always @(negedge clk) begin : mon
    fetch_t f;
    cpu_t   c;
    logic   rc_d1, pl_d1, pl_d2;
    int     last_cyc;
    if (bus.disp_fetch) begin
      n_fetch++;
      if (fq.size() == 0) begin
        check("fetch_unexpected", 1, 0);
      end else begin
        f = fq.pop_front();
        check("fetch_addr", bus.vram_addr, f.addr);
        check("rowclear_before_fetch", rc_d1, f.rc);
        check("preload_before_fetch", pl_d2, f.first);
        if (!f.first) check("fetch_gap", cyc - last_cyc, 8);
      end
      last_cyc = cyc;
    end
    if (bus.cpu_ack) begin
      if (cq.size() == 0) begin
        check("cpu_ack_unexpected", 1, 0);
      end else begin
        c = cq.pop_front();
        check("cpu_addr", bus.vram_addr, c.addr);
        check("cpu_we", bus.vram_we, c.we);
      end
    end
    if (bus.vram_we) check("we_with_ack", bus.cpu_ack, 1);
    if (rowclear) rc_seen++;
    rc_d1 = rowclear;
    pl_d2 = pl_d1;
    pl_d1 = preload;
  end

  task automatic hpulse();
    @(posedge clk); #1 hsn = 1'b0;
    @(posedge clk); #1 hsn = 1'b1;
    if (m_line != 511) m_line++;
    m_act = (m_line >= 25) && (m_line < 217);
  endtask

  task automatic fpulse();
    @(posedge clk); #1 fsn = 1'b0;
    @(posedge clk); #1 fsn = 1'b1;
    m_line = 0;
    m_row  = base_addr;
    m_scan = 0;
    repeat (4) @(posedge clk);
  endtask

  task automatic push_line(input int n);
    for (int i = 0; i < n; i++) begin
      fq.push_back('{addr: m_row + 13'(i), rc: (i == 0 && m_scan == 0), first: (i == 0)});
    end
    if (n > 0 && m_scan == 0) exp_rc++;
  endtask

  task automatic advance_row();
    m_scan++;
    if (m_scan == 12) begin
      m_scan = 0;
      m_row  = m_row + 13'd32;
    end
  endtask

  task automatic run_line();
    hpulse();
    if (m_act) begin
      push_line(32);
      advance_row();
      repeat (330) @(posedge clk);
    end else begin
      repeat (4) @(posedge clk);
    end
  endtask

  task automatic wait_fetches(input int n);
    int k = 0;
    while (n_fetch < n && k < 2000) begin
      @(posedge clk);
      k++;
    end
    if (n_fetch < n) check("fetch_timeout", n_fetch, n);
  endtask

  task automatic cpu_access(input logic [12:0] addr, input logic we, input int exp_lat,
                            input logic coll);
    int   lat = 0;
    logic df1 = 1'b0;
    cq.push_back('{addr: addr, we: we});
    bus.cpu_addr = addr;
    bus.cpu_we   = we;
    bus.cpu_req  = 1'b1;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) df1 = bus.disp_fetch;
      if (bus.cpu_ack) lat = k;
    end
    check("cpu_latency", lat, exp_lat);
    if (coll) check("collision_disp_first", df1, 1);
    @(posedge clk); #1 bus.cpu_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    logic [3:0] pat;
    reset = 1'b1;
    hsn = 1'b1;
    fsn = 1'b1;
    base_addr = '0;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_vram_addr", bus.vram_addr, 0);
    check("rst_active", active, 0);
    check("rst_flags", {bus.disp_fetch, bus.vram_we, bus.cpu_ack, preload, rowclear}, 0);
    @(posedge clk); #1 reset = 1'b0;

    // idle port: single access, then a held request
    cpu_access(13'h0123, 1'b1, 1, 1'b0);
    cq.push_back('{addr: 13'h0ABC, we: 1'b0});
    cq.push_back('{addr: 13'h0ABC, we: 1'b0});
    bus.cpu_addr = 13'h0ABC;
    bus.cpu_we = 1'b0;
    bus.cpu_req = 1'b1;
    pat = '0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      pat = {pat[2:0], bus.cpu_ack};
    end
    bus.cpu_req = 1'b0;
    check("held_req_pattern", pat, 4'b1010);
    repeat (3) @(posedge clk); #1;

    // frame A: base 0x0400, first active line carries the CPU tests
    base_addr = 13'h0400;
    fpulse();
    repeat (24) run_line();
    start = n_fetch;
    hpulse();
    check("first_active_line", m_act, 1);
    push_line(32);
    advance_row();
    fork
      repeat (330) @(posedge clk);
      begin
        repeat (10) @(posedge clk); #1;
        cpu_access(13'h0055, 1'b0, 1, 1'b0);
        wait_fetches(start + 3);
        repeat (6) @(posedge clk); #1;
        cpu_access(13'h1ABC, 1'b1, 2, 1'b1);
      end
    join
    repeat (12) run_line();

    // frame B: wrap-around base, then abort at slot 10
    base_addr = 13'h1FF0;
    fpulse();
    repeat (24) run_line();
    repeat (13) run_line();
    start = n_fetch;
    hpulse();
    push_line(11);
    wait_fetches(start + 11);
    hpulse();
    @(negedge clk);
    check("abort_active_before", active, 1);
    @(negedge clk);
    check("abort_active_after", active, 0);
    push_line(32);
    advance_row();
    repeat (330) @(posedge clk);
    repeat (11) run_line();

    // reset in the middle of a fetch line
    start = n_fetch;
    hpulse();
    push_line(4);
    wait_fetches(start + 4);
    #3 reset = 1'b1;
    #1;
    check("midrst_active", active, 0);
    check("midrst_vram_addr", bus.vram_addr, 0);
    check("midrst_flags", {bus.disp_fetch, bus.vram_we, bus.cpu_ack, preload, rowclear}, 0);
    m_line = 0;
    m_row = '0;
    m_scan = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    hpulse();
    repeat (80) @(posedge clk);
    @(negedge clk);
    check("idle_after_reset", active, 0);
    repeat (5) @(posedge clk);

    check("fetch_queue_left", fq.size(), 0);
    check("cpu_queue_left", cq.size(), 0);
    check("rowclear_count", rc_seen, exp_rc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
